// File: rtl/layer_sequencer_pkg.sv
// Shared types for the layer sequencer: fixed-point sample format and controller states.
package layer_sequencer_pkg;

    localparam int INTEGRAL_WIDTH = 8;
    localparam int FRACTION_WIDTH = 8;
    localparam int FP_W           = INTEGRAL_WIDTH + FRACTION_WIDTH;

    typedef logic signed [FP_W-1:0] fixed_point;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        FIRE  = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } seq_state_t;

    // Index counters need at least one bit even for single-entry vectors.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/layer_sequencer_result_serializer.sv
// Collects per-neuron results while capture is enabled, then streams them out one beat
// at a time in neuron order while drain is enabled.
module layer_sequencer_result_serializer
    import layer_sequencer_pkg::*;
#(
    parameter int NUM_NEURONS = 8
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        capture_i,
    input  logic                        drain_i,
    input  logic [NUM_NEURONS*FP_W-1:0] neuron_out_i,
    input  logic [NUM_NEURONS-1:0]      neuron_ready_i,
    input  logic                        out_ready_i,
    output logic                        out_valid_o,
    output logic [FP_W-1:0]             out_data_o,
    output logic                        out_last_o,
    output logic                        all_done_o,
    output logic                        drain_done_o
);

    localparam int              OW       = idx_w(NUM_NEURONS);
    localparam logic [OW-1:0]   LAST_IDX = OW'(NUM_NEURONS - 1);

    logic [NUM_NEURONS*FP_W-1:0] results_q, results_d;
    logic [NUM_NEURONS-1:0]      done_q, done_d;
    logic [NUM_NEURONS-1:0]      capture_mask;
    logic [OW-1:0]               out_idx_q, out_idx_d;
    logic                        beat;

    // Same-cycle pulses count toward completion so the controller can leave WAIT next edge.
    assign capture_mask = capture_i ? neuron_ready_i : '0;
    assign all_done_o   = &(done_q | capture_mask);

    assign beat         = drain_i && out_ready_i;
    assign out_valid_o  = drain_i;
    assign out_last_o   = drain_i && (out_idx_q == LAST_IDX);
    assign out_data_o   = drain_i ? results_q[out_idx_q*FP_W +: FP_W] : '0;
    assign drain_done_o = beat && (out_idx_q == LAST_IDX);

    always_comb begin
        results_d = results_q;
        done_d    = done_q | capture_mask;
        out_idx_d = out_idx_q;
        for (int j = 0; j < NUM_NEURONS; j++) begin
            if (capture_mask[j]) begin
                results_d[j*FP_W +: FP_W] = neuron_out_i[j*FP_W +: FP_W];
            end
        end
        if (drain_done_o) begin
            out_idx_d = '0;
            done_d    = '0;
        end else if (beat) begin
            out_idx_d = out_idx_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            results_q <= '0;
            done_q    <= '0;
            out_idx_q <= '0;
        end else begin
            results_q <= results_d;
            done_q    <= done_d;
            out_idx_q <= out_idx_d;
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// Deserialises an input sample stream into a vector, starts a neuron layer, and hands the
// collected results to the serializer for output.
module layer_sequencer
    import layer_sequencer_pkg::*;
#(
    parameter int NUM_INPUTS  = 16,
    parameter int NUM_NEURONS = 8
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [FP_W-1:0]             in_data,
    input  logic                        in_last,
    output logic [NUM_INPUTS*FP_W-1:0]  inputs,
    output logic                        inputs_ready,
    input  logic [NUM_NEURONS*FP_W-1:0] neuron_out,
    input  logic [NUM_NEURONS-1:0]      neuron_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [FP_W-1:0]             out_data,
    output logic                        out_last,
    output logic                        frame_error
);

    localparam int            IW        = idx_w(NUM_INPUTS);
    localparam logic [IW-1:0] LAST_IN   = IW'(NUM_INPUTS - 1);

    seq_state_t                 state_q, state_d;
    logic [IW-1:0]              in_idx_q, in_idx_d;
    logic [NUM_INPUTS*FP_W-1:0] inputs_q, inputs_d;
    logic                       frame_error_q, frame_error_d;
    logic                       is_final;
    logic                       all_done;
    logic                       drain_done;

    // Gated by reset_n so the handshake reads idle while reset is held.
    assign in_ready    = reset_n && (state_q == FILL);
    assign inputs      = inputs_q;
    assign frame_error = frame_error_q;
    assign is_final    = (in_idx_q == LAST_IN);

    always_comb begin
        state_d       = state_q;
        in_idx_d      = in_idx_q;
        inputs_d      = inputs_q;
        frame_error_d = frame_error_q;
        inputs_ready  = 1'b0;
        case (state_q)
            FILL: begin
                if (in_valid) begin
                    if (in_last && !is_final) begin
                        // Short frame: discard it and resynchronise on the next sample.
                        frame_error_d = 1'b1;
                        in_idx_d      = '0;
                    end else begin
                        inputs_d[in_idx_q*FP_W +: FP_W] = in_data;
                        if (is_final) begin
                            frame_error_d = frame_error_q | !in_last;
                            state_d       = FIRE;
                        end else begin
                            in_idx_d = in_idx_q + 1'b1;
                        end
                    end
                end
            end
            FIRE: begin
                inputs_ready = 1'b1;
                state_d      = WAIT;
            end
            WAIT: begin
                if (all_done) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_d  = FILL;
                    in_idx_d = '0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= FILL;
            in_idx_q      <= '0;
            inputs_q      <= '0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            in_idx_q      <= in_idx_d;
            inputs_q      <= inputs_d;
            frame_error_q <= frame_error_d;
        end
    end

    layer_sequencer_result_serializer #(
        .NUM_NEURONS (NUM_NEURONS)
    ) u_result_serializer (
        .clock          (clock),
        .reset_n        (reset_n),
        .capture_i      (state_q == WAIT),
        .drain_i        (state_q == DRAIN),
        .neuron_out_i   (neuron_out),
        .neuron_ready_i (neuron_ready),
        .out_ready_i    (out_ready),
        .out_valid_o    (out_valid),
        .out_data_o     (out_data),
        .out_last_o     (out_last),
        .all_done_o     (all_done),
        .drain_done_o   (drain_done)
    );

endmodule

// File: tb/tb_layer_sequencer.sv
// Randomized frame-level bench for layer_sequencer with a behavioural frame/result model.
module tb_layer_sequencer;
    import layer_sequencer_pkg::*;

    localparam int NI = 4;
    localparam int NN = 2;

    typedef logic [FP_W-1:0] word_t;

    logic                clock = 1'b0;
    logic                reset_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [FP_W-1:0]     in_data = '0;
    logic                in_last = 1'b0;
    logic [NI*FP_W-1:0]  inputs;
    logic                inputs_ready;
    logic [NN*FP_W-1:0]  neuron_out = '0;
    logic [NN-1:0]       neuron_ready = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [FP_W-1:0]     out_data;
    logic                out_last;
    logic                frame_error;

    layer_sequencer #(.NUM_INPUTS(NI), .NUM_NEURONS(NN)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .inputs(inputs), .inputs_ready(inputs_ready),
        .neuron_out(neuron_out), .neuron_ready(neuron_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .frame_error(frame_error)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model state: what the layer should hold, by frame rules alone.
    word_t              stim[NI];
    word_t              exp_vec[NI];
    word_t              exp_res[NN];
    logic               exp_err = 1'b0;
    logic [NN-1:0]      sm[$];
    logic [NN*FP_W-1:0] sv[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [NN*FP_W-1:0] rnd_lanes();
        logic [NN*FP_W-1:0] v;
        for (int j = 0; j < NN; j++) v[j*FP_W +: FP_W] = word_t'($urandom);
        return v;
    endfunction

    task automatic noise_neurons();
        neuron_ready = NN'($urandom);
        neuron_out   = rnd_lanes();
    endtask

    task automatic chk_vec(input string tag);
        for (int i = 0; i < NI; i++) chk(tag, inputs[i*FP_W +: FP_W], exp_vec[i]);
    endtask

    task automatic feed(input int nbeats, input int last_at);
        for (int b = 0; b < nbeats; b++) begin
            repeat ($urandom_range(0, 1)) begin
                in_valid = 1'b0;
                noise_neurons();
                chk("idle_in_ready", in_ready, 1);
                step();
            end
            in_valid = 1'b1;
            in_data  = stim[b];
            in_last  = (b == last_at);
            noise_neurons();
            chk("fill_in_ready", in_ready, 1);
            step();
        end
        in_valid     = 1'b0;
        in_last      = 1'b0;
        neuron_ready = '0;
    endtask

    task automatic wait_phase();
        logic [NN-1:0]      pend;
        logic [NN-1:0]      m;
        logic [NN*FP_W-1:0] v;
        int                 cyc;
        pend = '1;
        cyc  = 0;
        while (pend != '0) begin
            if (sm.size() > 0) begin
                m = sm.pop_front();
                v = sv.pop_front();
            end else begin
                m = (cyc > 6) ? pend : NN'($urandom);
                v = rnd_lanes();
            end
            neuron_ready = m;
            neuron_out   = v;
            in_valid     = 1'($urandom_range(0, 1));
            in_data      = word_t'($urandom);
            in_last      = 1'($urandom_range(0, 1));
            for (int j = 0; j < NN; j++) if (m[j]) exp_res[j] = v[j*FP_W +: FP_W];
            pend &= ~m;
            chk("wait_no_valid", out_valid, 0);
            chk("wait_in_ready", in_ready, 0);
            chk("wait_no_fire", inputs_ready, 0);
            chk_vec("wait_hold");
            step();
            cyc++;
        end
        neuron_ready = '0;
    endtask

    task automatic drain(input int dmode);
        int k;
        int cyc;
        bit rdy;
        k   = 0;
        cyc = 0;
        while (k < NN && cyc < 200) begin
            case (dmode)
                0:       rdy = 1'($urandom_range(0, 1));
                1:       rdy = (cyc % 2) == 1;
                default: rdy = 1'b1;
            endcase
            out_ready = rdy;
            noise_neurons();
            in_valid  = 1'b1;
            in_data   = word_t'($urandom);
            chk("drain_valid", out_valid, 1);
            chk("drain_data", out_data, exp_res[k]);
            chk("drain_last", out_last, (k == NN - 1));
            chk("drain_in_ready", in_ready, 0);
            step();
            cyc++;
            if (rdy) k++;
        end
        out_ready    = 1'b0;
        in_valid     = 1'b0;
        neuron_ready = '0;
        if (k < NN) chk("drain_timeout", k, NN);
        chk("drain_end_valid", out_valid, 0);
        chk("drain_back_fill", in_ready, 1);
        chk("drain_err", frame_error, exp_err);
    endtask

    // kind: 0 clean frame, 1 missing in_last on final beat, 2 early in_last (dropped)
    task automatic do_frame(input int kind, input bit keep, input int dmode);
        int pos;
        if (!keep) for (int i = 0; i < NI; i++) stim[i] = word_t'($urandom);
        if (kind == 2) begin
            pos = $urandom_range(0, NI - 2);
            feed(pos + 1, pos);
            exp_err = 1'b1;
            chk("drop_no_fire", inputs_ready, 0);
            chk("drop_in_ready", in_ready, 1);
            chk("drop_err", frame_error, exp_err);
            return;
        end
        feed(NI, (kind == 0) ? NI - 1 : -1);
        if (kind == 1) exp_err = 1'b1;
        for (int i = 0; i < NI; i++) exp_vec[i] = stim[i];
        chk("fire_pulse", inputs_ready, 1);
        chk("fire_in_ready", in_ready, 0);
        chk("fire_err", frame_error, exp_err);
        chk_vec("fire_vec");
        step();
        chk("fire_once", inputs_ready, 0);
        wait_phase();
        drain(dmode);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        @(negedge clock);
        reset_n = 1'b1;
        step();
        chk("rst_rel_in_ready", in_ready, 1);
        chk("rst_inputs_ready", inputs_ready, 0);
        chk("rst_out_valid2", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_frame_error", frame_error, 0);
        chk("rst_inputs", inputs, 0);

        // Directed frame: 1.0, 2.0, -1.0, 0.5; results 3.0 then -0.25 two cycles later
        stim[0] = 16'h0100; stim[1] = 16'h0200; stim[2] = 16'hFF00; stim[3] = 16'h0080;
        sm.push_back(2'b01); sv.push_back({16'h1234, 16'h0300});
        sm.push_back(2'b00); sv.push_back({16'h5555, 16'h5555});
        sm.push_back(2'b10); sv.push_back({16'hFFC0, 16'h7777});
        do_frame(0, 1'b1, 2);

        // Same-cycle completion with toggling out_ready
        sm.push_back(2'b11); sv.push_back({16'hABCD, 16'h0042});
        do_frame(0, 1'b0, 1);

        // Short frame then clean frame; error stays sticky
        stim[0] = 16'h0011; stim[1] = 16'h0022;
        feed(2, 1);
        exp_err = 1'b1;
        chk("short_no_fire", inputs_ready, 0);
        chk("short_err", frame_error, 1);
        repeat (2) begin
            chk("short_idle_no_fire", inputs_ready, 0);
            step();
        end
        do_frame(0, 1'b0, 0);

        for (int f = 0; f < 20; f++) begin
            int r;
            r = $urandom_range(0, 5);
            do_frame((r < 4) ? 0 : r - 3, 1'b0, $urandom_range(0, 2));
        end

        // Reset mid-WAIT with one result already captured
        for (int i = 0; i < NI; i++) stim[i] = word_t'($urandom);
        feed(NI, NI - 1);
        step();
        neuron_ready = 2'b01;
        neuron_out   = rnd_lanes();
        step();
        neuron_ready = '0;
        #2;
        reset_n = 1'b0;
        #1;
        exp_err = 1'b0;
        chk("arst_in_ready", in_ready, 0);
        chk("arst_inputs_ready", inputs_ready, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_last", out_last, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_frame_error", frame_error, 0);
        chk("arst_inputs", inputs, 0);
        @(negedge clock);
        reset_n = 1'b1;
        step();
        chk("arst_rel_in_ready", in_ready, 1);
        neuron_ready = 2'b10;
        neuron_out   = rnd_lanes();
        step();
        neuron_ready = '0;
        repeat (3) begin
            chk("late_pulse_no_valid", out_valid, 0);
            chk("late_pulse_in_ready", in_ready, 1);
            step();
        end

        // Stale done bits must not shorten the next WAIT
        sm.push_back(2'b10); sv.push_back(rnd_lanes());
        sm.push_back(2'b00); sv.push_back(rnd_lanes());
        sm.push_back(2'b01); sv.push_back(rnd_lanes());
        do_frame(0, 1'b0, 0);
        for (int f = 0; f < 5; f++) do_frame($urandom_range(0, 2), 1'b0, $urandom_range(0, 2));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
